// File: rtl/dds_pkg.sv
// dds_pkg: shared tuning-word width, reset word, sweep modes and FSM states for the dds path
package dds_pkg;
    localparam int W = 32;
    localparam logic [W-1:0] K_RESET = 32'd42949672;
    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_SAW = 2'b01;
    localparam logic [1:0] MODE_TRI = 2'b10;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/sweep_step_alu.sv
// sweep_step_alu: clamped up/down step of a tuning word inside [lo, hi]
module sweep_step_alu
    import dds_pkg::*;
(
    input  logic [W-1:0] k,
    input  logic [W-1:0] step,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  logic         down,
    output logic [W-1:0] k_next,
    output logic         at_hi,
    output logic         at_lo
);
    logic [W:0] sum;
    logic [W:0] diff;
    // the extra bit catches carry/borrow so the word clamps instead of wrapping
    assign sum = {1'b0, k} + {1'b0, step};
    assign diff = {1'b0, k} - {1'b0, step};
    assign k_next = down ? ((diff[W] || diff[W-1:0] <= lo) ? lo : diff[W-1:0])
                         : ((sum[W] || sum[W-1:0] >= hi) ? hi : sum[W-1:0]);
    assign at_hi = k == hi;
    assign at_lo = k == lo;
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the dds tuning word between start/stop words with a programmable dwell
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  f_start,
    input  logic [W-1:0]  f_stop,
    input  logic [W-1:0]  f_step,
    input  logic [DW-1:0] dwell,
    output logic [W-1:0]  K,
    output logic          Ken,
    output logic          busy,
    output logic          done
);
    state_t state, state_n;
    logic [1:0] mode_r;
    logic [W-1:0] fs, fe, fst, k_n, k_step;
    logic [DW-1:0] dwm1, cnt, cnt_n;
    logic dir, dir_n, pend, ken_n, busy_n, done_n, load, down, degen, at_hi, at_lo;

    assign degen = fst == '0 || fs >= fe;
    // triangle turns around when the current word sits on the limit it was heading for
    assign down = mode_r == MODE_TRI && (dir ? !at_lo : at_hi);

    sweep_step_alu alu (
        .k(K),
        .step(fst),
        .lo(fs),
        .hi(fe),
        .down(down),
        .k_next(k_step),
        .at_hi(at_hi),
        .at_lo(at_lo)
    );

    always_comb begin
        state_n = state;
        k_n = K;
        ken_n = pend;
        busy_n = busy;
        done_n = 1'b0;
        cnt_n = cnt;
        dir_n = dir;
        load = 1'b0;
        case (state)
            IDLE: if (start && !abort) begin
                load = 1'b1;
                state_n = RUN;
                k_n = f_start;
                ken_n = 1'b1;
                busy_n = 1'b1;
                cnt_n = (dwell == '0) ? '0 : dwell - DW'(1);
                dir_n = 1'b0;
            end
            RUN: if (abort) begin
                state_n = IDLE;
                busy_n = 1'b0;
            end else if (cnt != '0) begin
                cnt_n = cnt - DW'(1);
            end else if (mode_r == MODE_SINGLE && (degen || at_hi)) begin
                state_n = FIN;
                busy_n = 1'b0;
                done_n = 1'b1;
            end else if (!degen) begin
                k_n = (mode_r == MODE_SAW && at_hi) ? fs : k_step;
                ken_n = 1'b1;
                cnt_n = dwm1;
                dir_n = down;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            K <= K_RESET;
            Ken <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            cnt <= '0;
            dir <= 1'b0;
            pend <= 1'b1;
        end else begin
            state <= state_n;
            K <= k_n;
            Ken <= ken_n;
            busy <= busy_n;
            done <= done_n;
            cnt <= cnt_n;
            dir <= dir_n;
            pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            mode_r <= (mode == 2'b11) ? MODE_SINGLE : mode;
            fs <= f_start;
            fe <= f_stop;
            fst <= f_step;
            dwm1 <= (dwell == '0) ? '0 : dwell - DW'(1);
        end
    end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: scoreboard bench; a sweep-sequence model queues every expected Ken/done event
module tb_dds_sweep_ctrl;
    import dds_pkg::*;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [1:0] mode = '0;
    logic [W-1:0] f_start = '0;
    logic [W-1:0] f_stop = '0;
    logic [W-1:0] f_step = '0;
    logic [DW-1:0] dwell = '0;
    logic [W-1:0] K;
    logic Ken, busy, done;

    typedef struct {
        bit is_done;
        logic [W-1:0] k;
        bit bsy;
        int cyc;
    } ev_t;

    ev_t q[$];
    ev_t got;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    longint last_k;

    dds_sweep_ctrl #(.DW(DW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .mode(mode),
        .f_start(f_start),
        .f_stop(f_stop),
        .f_step(f_step),
        .dwell(dwell),
        .K(K),
        .Ken(Ken),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every Ken or done the DUT shows must match the next queued event
    always @(negedge clk) begin
        if (Ken || done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output cyc=%0d Ken=%0b done=%0b K=%h", cyc, Ken, done, K);
            end else begin
                got = q.pop_front();
                if (got.is_done != done || got.k != K || got.bsy != busy || got.cyc != cyc) begin
                    errors++;
                    $display("FAIL event got done=%0b K=%h busy=%0b cyc=%0d expected done=%0b K=%h busy=%0b cyc=%0d",
                             done, K, busy, cyc, got.is_done, got.k, got.bsy, got.cyc);
                end
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push(bit d, longint k, bit b, int t);
        ev_t ev;
        ev.is_done = d;
        ev.k = k[W-1:0];
        ev.bsy = b;
        ev.cyc = t;
        q.push_back(ev);
        last_k = k;
    endfunction

    // reference: walk the word sequence from the sweep rules; events at cycle >= a are cut by abort
    function automatic void model(int m, longint fs, longint fe, longint st, int dw, int e, int a);
        int d = (dw == 0) ? 1 : dw;
        int t = e;
        longint k = fs;
        bit dn = 1'b0;
        if (m == 3) m = 0;
        if (t >= a) return;
        push(1'b0, k, 1'b1, t);
        if (st == 0 || fs >= fe) begin
            if (m == 0 && t + d < a) push(1'b1, fs, 1'b0, t + d);
            return;
        end
        while (t + d < a) begin
            t += d;
            if (m == 0 && k == fe) begin
                push(1'b1, k, 1'b0, t);
                return;
            end
            if (m == 1 && k == fe) k = fs;
            else begin
                if (m == 2 && !dn && k == fe) dn = 1'b1;
                else if (m == 2 && dn && k == fs) dn = 1'b0;
                k = dn ? ((k - st < fs) ? fs : k - st) : ((k + st > fe) ? fe : k + st);
            end
            push(1'b0, k, 1'b1, t);
        end
    endfunction

    task automatic issue(int m, longint fs, longint fe, longint st, int dw, int alen, output int e, output int a);
        @(negedge clk);
        mode = m[1:0];
        f_start = fs[W-1:0];
        f_stop = fe[W-1:0];
        f_step = st[W-1:0];
        dwell = dw[DW-1:0];
        start = 1'b1;
        e = cyc + 1;
        a = e + alen;
        model(m, fs, fe, st, dw, e, a);
        @(negedge clk);
        start = 1'b0;
        mode = 2'($urandom);
        f_start = $urandom;
        f_stop = $urandom;
        f_step = $urandom;
        dwell = DW'($urandom_range(0, 7));
    endtask

    task automatic sweep(int m, longint fs, longint fe, longint st, int dw, int alen, bit mid);
        int e, a;
        issue(m, fs, fe, st, dw, alen, e, a);
        while (cyc < a - 1) begin
            start = mid && cyc == e + 1;
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
        chk("k_frozen", K, last_k[W-1:0]);
        chk("queue_empty", q.size(), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b0, K_RESET, 1'b0, cyc + 1);
        repeat (3) @(negedge clk);
        chk("reset_ken_seen", q.size(), 0);
    endtask

    initial begin
        int e, a;
        longint base, fs, fe, st;
        #12;
        chk("rst_k", K, K_RESET);
        chk("rst_ken", Ken, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        release_reset();

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        mode = MODE_SAW;
        f_start = 5;
        f_stop = 50;
        f_step = 5;
        dwell = 1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_abort_busy", busy, 0);
        chk("start_abort_k", K, K_RESET);

        sweep(0, 100, 130, 10, 3, 20, 1'b0);
        sweep(0, 100, 125, 10, 1, 10, 1'b0);
        sweep(0, 64'hFFFFFFF0, 64'hFFFFFFFF, 20, 2, 10, 1'b0);
        sweep(2, 0, 20, 10, 1, 9, 1'b0);
        sweep(1, 10, 40, 10, 2, 15, 1'b1);
        sweep(0, 0, 30, 10, 0, 8, 1'b0);
        sweep(1, 77, 200, 0, 2, 12, 1'b0);
        sweep(3, 5, 25, 10, 1, 10, 1'b0);
        sweep(0, 300, 200, 10, 2, 8, 1'b0);

        issue(2, 0, 40, 10, 2, 1000, e, a);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_k", K, K_RESET);
        chk("async_rst_ken", Ken, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        q.delete();
        release_reset();

        for (int i = 0; i < 30; i++) begin
            base = (i % 3 == 2) ? 64'hFFFFFE00 : 0;
            fs = base + $urandom_range(0, 200);
            fe = base + $urandom_range(0, 300);
            st = (i % 7 == 6) ? 64'hFFFFFF00 : $urandom_range(0, 40);
            sweep($urandom_range(0, 3), fs, fe, st, $urandom_range(0, 4), $urandom_range(1, 60), i[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
